uart_cfg: RTL and testbench
===========================

# uart_cfg

Parametrised full-duplex UART for the FPGA serial link, the next generation of the fixed-format 8N1 UART. It adds a runtime baud divisor, a compile-time data width and stop-bit count, optional even/odd parity, and framing, parity and overrun error reporting. A held-data receive handshake lets slow host logic consume bytes without losing error information. The block sits between the on-chip host/command logic and the board TX/RX pins.

## Interface
- DATA_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- NBITS_DIV, 16, width of baud_div
- clock  in  1  master clock
- reset  in  1  asynchronous, active-high master reset
- baud_div  in  NBITS_DIV  bit period minus one, in clocks; must be >= 3
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- txen  in  1  load din and start a frame; honoured only while txready=1
- din  in  DATA_BITS  data to transmit
- txready  out  1  high when the transmitter is idle
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous
- rxready  out  1  level; high while dout holds an unacknowledged frame
- rxack  in  1  single-cycle pulse; clears rxready and all error flags
- dout  out  DATA_BITS  last received data
- frame_err, parity_err, overrun  out  1 each  sticky until rxack

## Operation
- Reset values: tx=1, txready=1, rxready=0, dout=0, all error flags 0. Both FSMs go to idle; assertion takes effect immediately, including mid-frame.
- Frame format: start bit (0), data LSB first, optional parity bit, STOP_BITS stop bits (1).
- Bit period is P = baud_div+1 clocks. baud_div and parity_mode are latched at frame start (TX on txen, RX on start detect). Changes mid-frame have no effect on that frame.
- TX FSM states: T_IDLE -> T_START -> T_DATA (DATA_BITS bits) -> T_PARITY (only if parity is enabled) -> T_STOP (STOP_BITS bits) -> T_IDLE.
- Parity bit value: even mode sends XOR of the data bits; odd mode sends its inverse.
- txen while txready=0 is ignored.
- RX input path: 2-flop synchroniser followed by an edge register. A 1->0 transition seen in R_IDLE is a start detect.
- RX FSM states: R_IDLE -> R_START -> R_DATA -> R_PARITY (if enabled) -> R_STOP -> R_IDLE.
- RX sampling: first sample is taken floor(P/2) clocks after start detect, then every P clocks.
- If the start sample is 1, it is a false start: return to R_IDLE with no flags and no rxready.
- Parity check: a mismatch sets parity_err.
- Stop check: every stop bit is sampled; any 0 sets frame_err.
- Frame completion happens at the last stop-bit sample. Even an erroneous frame updates dout and sets rxready=1. The FSM returns to R_IDLE in the same cycle, so a start bit immediately following is caught.
- Overrun: a frame completing while rxready=1 sets overrun, and dout is overwritten with the newer frame.
- rxack in the same cycle as a frame completion: the completion wins. rxready stays 1, flags reflect the new frame only, and overrun is not set.
- TX and RX are fully independent. Simultaneous activity is legal.

## Timing
- txen is sampled at cycle 0. txready=0 and tx=0 (start bit) from cycle 1.
- A frame occupies N×P clocks from cycle 1, where N = 1+DATA_BITS+parity+STOP_BITS.
- txready returns to 1 in the cycle after the last stop bit ends. Back-to-back txen on that cycle yields gapless frames.
- rx edge to start detect: 3 clocks.
- Start sample to rxready rising: (N−1)×P clocks plus 1 register stage.
- Error flags and dout change in the same cycle that rxready rises.
- rxack clears rxready and the flags on the next clock edge.

## Configuration
- UART_PARITY_EN defined: parity_mode is honoured, and the parity bit is generated and checked.
- UART_PARITY_EN undefined: parity_mode is ignored, frames never carry a parity bit, parity_err is tied to 0, and the parity states are absent.

## Test plan
- Loopback (tx→rx), DATA_BITS=8, baud_div=9, parity none, din=0x55 -> tx frame lasts exactly 100 clocks; rxready=1, dout=0x55, no flags.
- Even parity, din=0x07 -> parity bit on the line is 1, parity_err=0. Inject the frame with parity 0 -> parity_err=1, dout=0x07.
- rx frame 0xA3 with the stop bit driven 0 -> frame_err=1, rxready=1, dout=0xA3. rxack clears both.
- Two frames 0x11 then 0x22 with no rxack -> overrun=1, dout=0x22. A single rxack clears rxready and overrun.
- rx low for 3 clocks with baud_div=9 -> false start: no rxready, no flags. A following valid frame 0x3C is received correctly.
- reset asserted mid-transmit, off a clock edge -> tx=1 and txready=1 immediately. txen pulsed during a frame is ignored, and the frame content is unchanged.

Source files
------------

// File: rtl/uart_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cfg
// Purpose  : Full-duplex UART with runtime baud divisor, compile-time frame
//            format and error reporting. Parity support: define UART_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_cfg #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int NBITS_DIV = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NBITS_DIV-1:0] baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 txen,
    input  logic [DATA_BITS-1:0] din,
    output logic                 txready,
    output logic                 tx,
    input  logic                 rx,
    output logic                 rxready,
    input  logic                 rxack,
    output logic [DATA_BITS-1:0] dout,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [3:0]           c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0]           c_last_stop = 4'(STOP_BITS - 1);
    localparam logic [3:0]           c_bit_one   = 4'd1;
    localparam logic [NBITS_DIV-1:0] c_div_one   = NBITS_DIV'(1);

    typedef enum logic [2:0] {
        T_IDLE   = 3'd0,
        T_START  = 3'd1,
        T_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        T_PARITY = 3'd3,
`endif
        T_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE   = 3'd0,
        R_START  = 3'd1,
        R_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        R_PARITY = 3'd3,
`endif
        R_STOP   = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------ TX
    tx_state_t              r_tx_state, w_tx_state_nxt;
    logic [NBITS_DIV-1:0]   r_tx_cnt, w_tx_cnt_nxt;
    logic [NBITS_DIV-1:0]   r_tx_div, w_tx_div_nxt;
    logic [3:0]             r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0]   r_tx_shift, w_tx_shift_nxt;
    logic                   r_tx, w_tx_nxt;
    logic                   w_tx_tick;
`ifdef UART_PARITY_EN
    logic                   r_tx_par_en, w_tx_par_en_nxt;
    logic                   r_tx_par, w_tx_par_nxt;
`endif

    assign w_tx_tick = (r_tx_cnt == '0);
    assign txready   = (r_tx_state == T_IDLE);
    assign tx        = r_tx;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_div_nxt   = r_tx_div;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_nxt       = r_tx;
`ifdef UART_PARITY_EN
        w_tx_par_en_nxt = r_tx_par_en;
        w_tx_par_nxt    = r_tx_par;
`endif
        if (r_tx_state != T_IDLE) begin
            w_tx_cnt_nxt = w_tx_tick ? r_tx_div : r_tx_cnt - c_div_one;
        end
        case (r_tx_state)
            T_IDLE: begin
                if (txen) begin
                    w_tx_state_nxt = T_START;
                    w_tx_cnt_nxt   = baud_div;
                    w_tx_div_nxt   = baud_div;
                    w_tx_shift_nxt = din;
                    w_tx_bit_nxt   = '0;
                    w_tx_nxt       = 1'b0;
`ifdef UART_PARITY_EN
                    w_tx_par_en_nxt = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    w_tx_par_nxt    = (^din) ^ (parity_mode == 2'b10);
`endif
                end
            end
            T_START: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = T_DATA;
                    w_tx_nxt       = r_tx_shift[0];
                    w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                end
            end
            T_DATA: begin
                if (w_tx_tick) begin
                    if (r_tx_bit == c_last_data) begin
                        w_tx_bit_nxt   = '0;
                        w_tx_state_nxt = T_STOP;
                        w_tx_nxt       = 1'b1;
`ifdef UART_PARITY_EN
                        if (r_tx_par_en) begin
                            w_tx_state_nxt = T_PARITY;
                            w_tx_nxt       = r_tx_par;
                        end
`endif
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + c_bit_one;
                        w_tx_nxt       = r_tx_shift[0];
                        w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_PARITY_EN
            T_PARITY: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = T_STOP;
                    w_tx_nxt       = 1'b1;
                end
            end
`endif
            T_STOP: begin
                if (w_tx_tick) begin
                    if (r_tx_bit == c_last_stop) begin
                        w_tx_state_nxt = T_IDLE;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + c_bit_one;
                    end
                end
            end
            default: begin
                w_tx_state_nxt = T_IDLE;
                w_tx_nxt       = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------ RX
    rx_state_t              r_rx_state, w_rx_state_nxt;
    logic                   r_rx_s1, r_rx_s2, r_rx_d;
    logic [NBITS_DIV-1:0]   r_rx_cnt, w_rx_cnt_nxt;
    logic [NBITS_DIV-1:0]   r_rx_div, w_rx_div_nxt;
    logic [3:0]             r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0]   r_rx_shift, w_rx_shift_nxt;
    logic                   r_rx_ferr, w_rx_ferr_nxt;
    logic                   w_rx_tick, w_rx_done, w_rx_ferr_frame;
    logic [NBITS_DIV-1:0]   w_rx_half_m1;
    logic                   r_rxready, w_rxready_nxt;
    logic [DATA_BITS-1:0]   r_dout, w_dout_nxt;
    logic                   r_frame_err, w_frame_err_nxt;
    logic                   r_overrun, w_overrun_nxt;
`ifdef UART_PARITY_EN
    logic                   r_rx_par_en, w_rx_par_en_nxt;
    logic                   r_rx_odd, w_rx_odd_nxt;
    logic                   r_rx_perr, w_rx_perr_nxt;
    logic                   r_parity_err, w_parity_err_nxt;

    assign parity_err = r_parity_err;
`else
    logic                   w_unused_parity;

    assign w_unused_parity = ^parity_mode;
    assign parity_err      = 1'b0;
`endif

    // floor(P/2) - 1, with P = baud_div + 1
    assign w_rx_half_m1    = (baud_div >> 1) + NBITS_DIV'(baud_div[0]) - c_div_one;
    assign w_rx_tick       = (r_rx_cnt == '0);
    assign w_rx_ferr_frame = r_rx_ferr | ~r_rx_s2;
    assign rxready         = r_rxready;
    assign dout            = r_dout;
    assign frame_err       = r_frame_err;
    assign overrun         = r_overrun;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_div_nxt   = r_rx_div;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_ferr_nxt  = r_rx_ferr;
        w_rx_done      = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_en_nxt = r_rx_par_en;
        w_rx_odd_nxt    = r_rx_odd;
        w_rx_perr_nxt   = r_rx_perr;
`endif
        if (r_rx_state != R_IDLE) begin
            w_rx_cnt_nxt = w_rx_tick ? r_rx_div : r_rx_cnt - c_div_one;
        end
        case (r_rx_state)
            R_IDLE: begin
                if (r_rx_d && !r_rx_s2) begin
                    w_rx_state_nxt = R_START;
                    w_rx_cnt_nxt   = w_rx_half_m1;
                    w_rx_div_nxt   = baud_div;
                    w_rx_bit_nxt   = '0;
                    w_rx_ferr_nxt  = 1'b0;
`ifdef UART_PARITY_EN
                    w_rx_par_en_nxt = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    w_rx_odd_nxt    = (parity_mode == 2'b10);
                    w_rx_perr_nxt   = 1'b0;
`endif
                end
            end
            R_START: begin
                if (w_rx_tick) begin
                    w_rx_state_nxt = r_rx_s2 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (w_rx_tick) begin
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == c_last_data) begin
                        w_rx_bit_nxt   = '0;
                        w_rx_state_nxt = R_STOP;
`ifdef UART_PARITY_EN
                        if (r_rx_par_en) begin
                            w_rx_state_nxt = R_PARITY;
                        end
`endif
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + c_bit_one;
                    end
                end
            end
`ifdef UART_PARITY_EN
            R_PARITY: begin
                if (w_rx_tick) begin
                    w_rx_perr_nxt  = (^r_rx_shift) ^ r_rx_s2 ^ r_rx_odd;
                    w_rx_state_nxt = R_STOP;
                end
            end
`endif
            R_STOP: begin
                if (w_rx_tick) begin
                    w_rx_ferr_nxt = w_rx_ferr_frame;
                    if (r_rx_bit == c_last_stop) begin
                        w_rx_done      = 1'b1;
                        w_rx_state_nxt = R_IDLE;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + c_bit_one;
                    end
                end
            end
            default: w_rx_state_nxt = R_IDLE;
        endcase

        // Host side: a completing frame takes priority over rxack
        w_rxready_nxt   = r_rxready;
        w_dout_nxt      = r_dout;
        w_frame_err_nxt = r_frame_err;
        w_overrun_nxt   = r_overrun;
`ifdef UART_PARITY_EN
        w_parity_err_nxt = r_parity_err;
`endif
        if (w_rx_done) begin
            w_rxready_nxt = 1'b1;
            w_dout_nxt    = r_rx_shift;
            if (rxack) begin
                w_frame_err_nxt = w_rx_ferr_frame;
                w_overrun_nxt   = 1'b0;
`ifdef UART_PARITY_EN
                w_parity_err_nxt = r_rx_perr;
`endif
            end else begin
                w_frame_err_nxt = r_frame_err | w_rx_ferr_frame;
                w_overrun_nxt   = r_overrun | r_rxready;
`ifdef UART_PARITY_EN
                w_parity_err_nxt = r_parity_err | r_rx_perr;
`endif
            end
        end else if (rxack) begin
            w_rxready_nxt   = 1'b0;
            w_frame_err_nxt = 1'b0;
            w_overrun_nxt   = 1'b0;
`ifdef UART_PARITY_EN
            w_parity_err_nxt = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state  <= T_IDLE;
            r_tx_cnt    <= '0;
            r_tx_div    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx        <= 1'b1;
            r_rx_state  <= R_IDLE;
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_d      <= 1'b1;
            r_rx_cnt    <= '0;
            r_rx_div    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_ferr   <= 1'b0;
            r_rxready   <= 1'b0;
            r_dout      <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par_en  <= 1'b0;
            r_tx_par     <= 1'b0;
            r_rx_par_en  <= 1'b0;
            r_rx_odd     <= 1'b0;
            r_rx_perr    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_tx_state  <= w_tx_state_nxt;
            r_tx_cnt    <= w_tx_cnt_nxt;
            r_tx_div    <= w_tx_div_nxt;
            r_tx_bit    <= w_tx_bit_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_tx        <= w_tx_nxt;
            r_rx_state  <= w_rx_state_nxt;
            r_rx_s1     <= rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_d      <= r_rx_s2;
            r_rx_cnt    <= w_rx_cnt_nxt;
            r_rx_div    <= w_rx_div_nxt;
            r_rx_bit    <= w_rx_bit_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_rx_ferr   <= w_rx_ferr_nxt;
            r_rxready   <= w_rxready_nxt;
            r_dout      <= w_dout_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
`ifdef UART_PARITY_EN
            r_tx_par_en  <= w_tx_par_en_nxt;
            r_tx_par     <= w_tx_par_nxt;
            r_rx_par_en  <= w_rx_par_en_nxt;
            r_rx_odd     <= w_rx_odd_nxt;
            r_rx_perr    <= w_rx_perr_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cfg
// Purpose  : Directed scoreboard bench for uart_cfg (8 data bits, 1 stop bit).
// Revision : 1.0
// ============================================================================
module tb_uart_cfg;

    localparam int P = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = 16'd9;
    logic [1:0]  parity_mode = 2'b00;
    logic        txen = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        txready, tx, rx;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        rxready;
    logic        rxack = 1'b0;
    logic [7:0]  dout;
    logic        frame_err, parity_err, overrun;

    assign rx = loop ? tx : rx_drv;

    uart_cfg #(.DATA_BITS(8), .STOP_BITS(1), .NBITS_DIV(16)) dut (
        .clock(clock), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
        .txen(txen), .din(din), .txready(txready), .tx(tx), .rx(rx),
        .rxready(rxready), .rxack(rxack), .dout(dout),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       ov;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe, input logic ov);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe; e.ov = ov;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Starts a frame and records the line at each bit centre until txready returns.
    task automatic send_tx(input logic [7:0] d, input int pulse_at, input logic [7:0] pulse_d,
                           output logic [15:0] bits, output int len);
        bits = '1;
        len  = 0;
        din  = d;
        txen = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clock);
            #1;
            txen = 1'b0;
            if (txready) break;
            len++;
            if (((len - 1) % P == P / 2) && ((len - 1) / P < 16)) bits[(len - 1) / P] = tx;
            if (len == pulse_at) begin
                txen = 1'b1;
                din  = pulse_d;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic use_par, input logic par, input logic stop);
        rx_drv = 1'b0;
        cyc(P);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            cyc(P);
        end
        if (use_par) begin
            rx_drv = par;
            cyc(P);
        end
        rx_drv = stop;
        cyc(P);
        rx_drv = 1'b1;
    endtask

    task automatic check_rx(input string tag);
        exp_t e;
        int   w;
        w = 0;
        while (!rxready && w < 300) begin
            cyc(1);
            w++;
        end
        chk({tag, " rxready"}, rxready, 1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s sb: observed empty expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, " dout"}, dout, e.d);
            chk({tag, " frame_err"}, frame_err, e.fe);
            chk({tag, " parity_err"}, parity_err, e.pe);
            chk({tag, " overrun"}, overrun, e.ov);
        end
    endtask

    task automatic ack(input string tag);
        rxack = 1'b1;
        cyc(1);
        rxack = 1'b0;
        chk({tag, " ack rxready"}, rxready, 0);
        chk({tag, " ack flags"}, {frame_err, parity_err, overrun}, 0);
    endtask

    initial begin
        logic [15:0] bits;
        int          len;
        logic [7:0]  pd;

        // Reset values
        cyc(3);
        chk("rst tx", tx, 1);
        chk("rst txready", txready, 1);
        chk("rst rxready", rxready, 0);
        chk("rst dout", dout, 0);
        chk("rst frame_err", frame_err, 0);
        chk("rst parity_err", parity_err, 0);
        chk("rst overrun", overrun, 0);
        reset = 1'b0;
        cyc(2);

        // Loopback 0x55, no parity: 10 bits x 10 clocks
        loop = 1'b1;
        sb.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        send_tx(8'h55, 0, 8'h00, bits, len);
        chk("lb55 len", len, 100);
        chk("lb55 bits", bits[9:0], {1'b1, 8'h55, 1'b0});
        check_rx("lb55");
        ack("lb55");

        // Stop bit driven low
        loop = 1'b0;
        cyc(5);
        sb.push_back(mk(8'hA3, 1'b1, 1'b0, 1'b0));
        send_rx(8'hA3, 1'b0, 1'b0, 1'b0);
        check_rx("ferr");
        ack("ferr");
        cyc(5);

        // Two frames without acknowledge
        sb.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
        send_rx(8'h11, 1'b0, 1'b0, 1'b1);
        check_rx("ovr1");
        send_rx(8'h22, 1'b0, 1'b0, 1'b1);
        cyc(3);
        sb.push_back(mk(8'h22, 1'b0, 1'b0, 1'b1));
        check_rx("ovr2");
        ack("ovr");

        // False start then valid frame
        rx_drv = 1'b0;
        cyc(3);
        rx_drv = 1'b1;
        cyc(30);
        chk("false rxready", rxready, 0);
        chk("false flags", {frame_err, parity_err, overrun}, 0);
        sb.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
        send_rx(8'h3C, 1'b0, 1'b0, 1'b1);
        check_rx("after_false");
        ack("after_false");

        // Reset mid-transmit, asserted between clock edges
        loop = 1'b1;
        din  = 8'h00;
        txen = 1'b1;
        cyc(1);
        txen = 1'b0;
        cyc(30);
        chk("pre_rst tx", tx, 0);
        chk("pre_rst txready", txready, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst tx", tx, 1);
        chk("midrst txready", txready, 1);
        @(negedge clock);
        reset = 1'b0;
        cyc(3);
        chk("midrst rxready", rxready, 0);

        // txen during a frame must be ignored
        sb.push_back(mk(8'h96, 1'b0, 1'b0, 1'b0));
        send_tx(8'h96, 40, 8'hFF, bits, len);
        chk("ign len", len, 100);
        chk("ign bits", bits[9:0], {1'b1, 8'h96, 1'b0});
        check_rx("ign");
        ack("ign");
        cyc(3);
        chk("ign idle", txready, 1);

`ifdef UART_PARITY_EN
        // Even parity loopback, then injected wrong parity bit
        parity_mode = 2'b01;
        pd = 8'h07;
        sb.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
        send_tx(pd, 0, 8'h00, bits, len);
        chk("par len", len, 110);
        chk("par bit", bits[9], ^pd);
        chk("par bits", bits[10:0], {1'b1, ^pd, pd, 1'b0});
        check_rx("par_lb");
        ack("par_lb");
        loop = 1'b0;
        cyc(5);
        sb.push_back(mk(8'h07, 1'b0, 1'b1, 1'b0));
        send_rx(8'h07, 1'b1, 1'b0, 1'b1);
        check_rx("par_bad");
        ack("par_bad");
`else
        pd = 8'h00;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
